// File: rtl/dual_serial_detector_pkg.sv
// Shared state encoding and default sizes for the dual serial detector.
package dual_serial_detector_pkg;

    typedef enum logic {
        DSD_FILL = 1'b0,
        DSD_RUN  = 1'b1
    } dsd_state_t;

    localparam int DSD_LEN   = 4;
    localparam int DSD_CNT_W = 8;

endpackage

// File: rtl/dual_serial_detector_window.sv
// Shift register holding the last LEN samples of one serial channel.
module serial_window #(
    parameter int LEN = 4
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           en,
    input  logic           d,
    output logic [LEN-1:0] win
);

    always_ff @(posedge clk) begin
        if (reset) begin
            win <= '0;
        end else if (en) begin
            win <= {win[LEN-2:0], d};
        end
    end

endmodule

// File: rtl/dual_serial_detector.sv
// Two-channel serial pattern detector with overlap mode and hit counter.
// Define HIT_COUNTER_EN to build the saturating hit counter; otherwise it reads 0.
module dual_serial_detector
    import dual_serial_detector_pkg::*;
#(
    parameter int             LEN   = DSD_LEN,
    parameter logic [LEN-1:0] PAT_A = 4'b0111,
    parameter logic [LEN-1:0] PAT_B = 4'b0001,
    parameter int             CNT_W = DSD_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             overlap,
    input  logic             a,
    input  logic             b,
    output logic             and1,
    output logic             match,
    output logic             filled,
    output logic [CNT_W-1:0] hit_count
);

    localparam int FW = (LEN > 2) ? $clog2(LEN) : 1;

    dsd_state_t     state;
    logic [FW-1:0]  fill_cnt;
    logic [LEN-1:0] win_a;
    logic [LEN-1:0] win_b;
    logic [LEN-1:0] nxt_a;
    logic [LEN-1:0] nxt_b;
    logic           last_fill;
    logic           hit;

    serial_window #(.LEN(LEN)) u_wa (
        .clk   (clk),
        .reset (reset),
        .en    (en),
        .d     (a),
        .win   (win_a)
    );

    serial_window #(.LEN(LEN)) u_wb (
        .clk   (clk),
        .reset (reset),
        .en    (en),
        .d     (b),
        .win   (win_b)
    );

    // Compare against the windows as they will be after this edge.
    assign nxt_a     = {win_a[LEN-2:0], a};
    assign nxt_b     = {win_b[LEN-2:0], b};
    assign last_fill = (state == DSD_FILL) && (fill_cnt == FW'(LEN - 1));
    assign hit       = en && (nxt_a == PAT_A) && (nxt_b == PAT_B)
                       && ((state == DSD_RUN) || last_fill);
    assign filled    = (state == DSD_RUN);

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= DSD_FILL;
            fill_cnt <= '0;
            and1     <= 1'b0;
            match    <= 1'b0;
        end else if (en) begin
            and1  <= a & b;
            match <= hit;
            if (hit && !overlap) begin
                state    <= DSD_FILL;
                fill_cnt <= '0;
            end else if (state == DSD_FILL) begin
                if (last_fill) begin
                    state    <= DSD_RUN;
                    fill_cnt <= '0;
                end else begin
                    fill_cnt <= fill_cnt + 1'b1;
                end
            end
        end else begin
            match <= 1'b0;
        end
    end

`ifdef HIT_COUNTER_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            hit_count <= '0;
        end else if (hit && (hit_count != {CNT_W{1'b1}})) begin
            hit_count <= hit_count + 1'b1;
        end
    end
`else
    assign hit_count = '0;
`endif

endmodule

// File: tb/tb_dual_serial_detector.sv
// Directed bench: default-pattern, all-ones pattern and narrow-counter instances.
module tb_dual_serial_detector;

`ifdef HIT_COUNTER_EN
    localparam bit HC_ON = 1'b1;
`else
    localparam bit HC_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset, en, overlap, a, b;

    logic       and1_0, match_0, filled_0;
    logic [7:0] hc_0;
    logic       and1_1, match_1, filled_1;
    logic [7:0] hc_1;
    logic       and1_2, match_2, filled_2;
    logic [1:0] hc_2;

    int total = 0;
    int bad   = 0;
    int nm;

    always #5 clk = ~clk;

    dual_serial_detector u0 (
        .clk(clk), .reset(reset), .en(en), .overlap(overlap),
        .a(a), .b(b), .and1(and1_0), .match(match_0),
        .filled(filled_0), .hit_count(hc_0)
    );

    dual_serial_detector #(
        .PAT_A(4'b1111), .PAT_B(4'b0000)
    ) u1 (
        .clk(clk), .reset(reset), .en(en), .overlap(overlap),
        .a(a), .b(b), .and1(and1_1), .match(match_1),
        .filled(filled_1), .hit_count(hc_1)
    );

    dual_serial_detector #(
        .PAT_A(4'b1111), .PAT_B(4'b0000), .CNT_W(2)
    ) u2 (
        .clk(clk), .reset(reset), .en(en), .overlap(overlap),
        .a(a), .b(b), .and1(and1_2), .match(match_2),
        .filled(filled_2), .hit_count(hc_2)
    );

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d want=%0d", tag, got, exp);
        end
    endtask

    task automatic step(input logic e, input logic sa, input logic sb);
        en = e;
        a  = sa;
        b  = sb;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step(1'b1, 1'b1, 1'b1);
        reset = 1'b0;
    endtask

    function automatic int hc(input int n);
        return HC_ON ? n : 0;
    endfunction

    initial begin
        reset = 1'b1; en = 1'b1; overlap = 1'b1; a = 1'b1; b = 1'b1;

        // reset held two edges with a=b=1
        step(1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b1);
        chk("rst_and1", and1_0, 0);
        chk("rst_match", match_0, 0);
        chk("rst_filled", filled_0, 0);
        chk("rst_hc", hc_0, 0);
        chk("rst_hc2", hc_2, 0);
        reset = 1'b0;

        // basic hit, overlap on
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        chk("basic_pre_match", match_0, 0);
        chk("basic_pre_filled", filled_0, 0);
        step(1'b1, 1'b1, 1'b1);
        chk("basic_match", match_0, 1);
        chk("basic_filled", filled_0, 1);
        chk("basic_hc", hc_0, hc(1));
        chk("basic_and1", and1_0, 1);
        step(1'b1, 1'b0, 1'b0);
        chk("basic_match_off", match_0, 0);
        chk("basic_and1_off", and1_0, 0);

        // all-ones / all-zeros stream, overlapping
        do_reset();
        overlap = 1'b1;
        nm = 0;
        for (int k = 1; k <= 10; k++) begin
            step(1'b1, 1'b1, 1'b0);
            chk($sformatf("ovl1_e%0d", k), match_1, (k >= 4) ? 1 : 0);
            nm += int'(match_1);
        end
        chk("ovl1_count", nm, 7);
        chk("ovl1_hc", hc_1, hc(7));
        chk("sat_hc", hc_2, hc(3));
        chk("ovl1_and1", and1_1, 0);

        // same stream, non-overlapping
        do_reset();
        overlap = 1'b0;
        nm = 0;
        for (int k = 1; k <= 10; k++) begin
            step(1'b1, 1'b1, 1'b0);
            chk($sformatf("ovl0_e%0d", k), match_1, (k == 4 || k == 8) ? 1 : 0);
            nm += int'(match_1);
        end
        chk("ovl0_count", nm, 2);
        chk("ovl0_hc", hc_1, hc(2));
        chk("ovl0_filled", filled_1, 0);

        // enable gaps between bits 2 and 3
        do_reset();
        overlap = 1'b1;
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        for (int k = 0; k < 3; k++) begin
            step(1'b0, 1'b1, 1'b1);
            chk("gap_match", match_0, 0);
            chk("gap_and1", and1_0, 0);
            chk("gap_filled", filled_0, 0);
        end
        step(1'b1, 1'b1, 1'b0);
        chk("gap_pre_match", match_0, 0);
        step(1'b1, 1'b1, 1'b1);
        chk("gap_match_hit", match_0, 1);
        chk("gap_hc", hc_0, hc(1));
        step(1'b0, 1'b0, 1'b0);
        chk("gap_en0_match", match_0, 0);
        chk("gap_en0_and1", and1_0, 1);
        chk("gap_en0_filled", filled_0, 1);

        // reset in the middle of a hit
        do_reset();
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        do_reset();
        chk("mid_rst_match", match_0, 0);
        step(1'b1, 1'b1, 1'b1);
        chk("mid_match", match_0, 0);
        chk("mid_filled", filled_0, 0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b1);
        chk("mid_rehit", match_0, 1);
        chk("mid_rehit_filled", filled_0, 1);

        // and1 follows each sampled a&b
        for (int k = 0; k < 4; k++) begin
            step(1'b1, k[1], k[0]);
            chk($sformatf("and1_%0d", k), and1_0, (k == 3) ? 1 : 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
